// File: rtl/game_sequencer_if.sv
// Handshake bundle between the game sequencer and the playfield datapath / buttons.
interface game_sequencer_if #(
  parameter int unsigned PERIOD_W = 22
);
  logic                move_r;
  logic                move_l;
  logic                move_u;
  logic                move_d;
  logic                hit;
  logic                miss;
  logic                frog_tick;
  logic                ball_tick;
  logic                running;
  logic                game_reset;
  logic [1:0]          state;
  logic [PERIOD_W-1:0] ball_period;
  logic [11:0]         score_cur;
  logic [11:0]         score_best;

  modport master (
    input  move_r, move_l, move_u, move_d, hit, miss,
    output frog_tick, ball_tick, running, game_reset, state, ball_period, score_cur, score_best
  );

  modport slave (
    output move_r, move_l, move_u, move_d, hit, miss,
    input  frog_tick, ball_tick, running, game_reset, state, ball_period, score_cur, score_best
  );
endinterface

// File: rtl/game_sequencer.sv
// Frogger/ball game controller: idle/run/over sequencing, movement tick generation,
// ball speed-up on hits and BCD current/best score keeping.
module game_sequencer #(
  parameter int unsigned PERIOD_W         = 22,
  parameter int unsigned FROG_PERIOD      = 2000000,
  parameter int unsigned BALL_PERIOD_INIT = 2000000,
  parameter int unsigned BALL_PERIOD_STEP = 100000,
  parameter int unsigned BALL_PERIOD_MIN  = 800000,
  parameter int unsigned OVER_HOLD        = 50000000
) (
  input logic               CLOCK_50,
  input logic               reset,
  game_sequencer_if.master  bus
);

  localparam logic [1:0] StIdle = 2'b00;
  localparam logic [1:0] StRun  = 2'b01;
  localparam logic [1:0] StOver = 2'b10;

  localparam logic [PERIOD_W-1:0] POne       = PERIOD_W'(1);
  localparam logic [PERIOD_W-1:0] FrogLast   = PERIOD_W'(FROG_PERIOD - 1);
  localparam logic [PERIOD_W-1:0] PeriodInit = PERIOD_W'(BALL_PERIOD_INIT);
  localparam logic [PERIOD_W-1:0] PeriodStep = PERIOD_W'(BALL_PERIOD_STEP);
  localparam logic [PERIOD_W-1:0] PeriodMin  = PERIOD_W'(BALL_PERIOD_MIN);

  // The over-hold interval (1 s at 50 MHz) does not fit the period width, so it gets its own.
  localparam int unsigned      HoldW    = (OVER_HOLD > 1) ? $clog2(OVER_HOLD) : 1;
  localparam logic [HoldW-1:0] HOne     = HoldW'(1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(OVER_HOLD - 1);

  logic [3:0]          btn_s1_q, btn_s2_q;
  logic [2:0]          hit_s_q;
  logic [1:0]          miss_s_q;
  logic [1:0]          state_q, state_d;
  logic [PERIOD_W-1:0] frog_cnt_q, frog_cnt_d;
  logic [PERIOD_W-1:0] ball_cnt_q, ball_cnt_d;
  logic [HoldW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [PERIOD_W-1:0] ball_period_q, ball_period_d;
  logic [11:0]         score_cur_q, score_cur_d;
  logic [11:0]         score_best_q, score_best_d;

  logic any_press, hit_ev, miss_s, frog_tick, ball_tick;

  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v != 12'h999) begin
      if (v[3:0] == 4'd9) begin
        r[3:0] = 4'd0;
        if (v[7:4] == 4'd9) begin
          r[7:4]  = 4'd0;
          r[11:8] = v[11:8] + 4'd1;
        end else begin
          r[7:4] = v[7:4] + 4'd1;
        end
      end else begin
        r[3:0] = v[3:0] + 4'd1;
      end
    end
    return r;
  endfunction

  assign any_press = ~&btn_s2_q;
  assign hit_ev    = hit_s_q[1] & ~hit_s_q[2];
  assign miss_s    = miss_s_q[1];
  assign frog_tick = (state_q == StRun) && (frog_cnt_q == FrogLast);
  // >= rather than == so a period shrinking under the running count still fires once.
  assign ball_tick = (state_q == StRun) && (ball_cnt_q >= ball_period_q - POne);

  always_comb begin
    state_d       = state_q;
    frog_cnt_d    = frog_cnt_q;
    ball_cnt_d    = ball_cnt_q;
    hold_cnt_d    = hold_cnt_q;
    ball_period_d = ball_period_q;
    score_cur_d   = score_cur_q;
    score_best_d  = score_best_q;
    case (state_q)
      StIdle: begin
        frog_cnt_d = '0;
        ball_cnt_d = '0;
        hold_cnt_d = '0;
        if (any_press) begin
          state_d       = StRun;
          score_cur_d   = '0;
          ball_period_d = PeriodInit;
        end
      end
      StRun: begin
        frog_cnt_d = frog_tick ? '0 : frog_cnt_q + POne;
        ball_cnt_d = ball_tick ? '0 : ball_cnt_q + POne;
        if (miss_s) begin
          state_d = StOver;
          if (score_cur_q > score_best_q) begin
            score_best_d = score_cur_q;
          end
        end else if (hit_ev) begin
          score_cur_d = bcd_inc(score_cur_q);
          if (ball_period_q > PeriodMin) begin
            ball_period_d = (ball_period_q - PeriodMin > PeriodStep) ?
                            ball_period_q - PeriodStep : PeriodMin;
          end
        end
      end
      StOver: begin
        frog_cnt_d = '0;
        ball_cnt_d = '0;
        if (hold_cnt_q == HoldLast) begin
          hold_cnt_d = '0;
          state_d    = StIdle;
        end else begin
          hold_cnt_d = hold_cnt_q + HOne;
        end
      end
      default: begin
        state_d    = StIdle;
        frog_cnt_d = '0;
        ball_cnt_d = '0;
        hold_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      btn_s1_q      <= 4'hF;
      btn_s2_q      <= 4'hF;
      hit_s_q       <= '0;
      miss_s_q      <= '0;
      state_q       <= StIdle;
      frog_cnt_q    <= '0;
      ball_cnt_q    <= '0;
      hold_cnt_q    <= '0;
      ball_period_q <= PeriodInit;
      score_cur_q   <= '0;
      score_best_q  <= '0;
    end else begin
      btn_s1_q      <= {bus.move_d, bus.move_u, bus.move_l, bus.move_r};
      btn_s2_q      <= btn_s1_q;
      hit_s_q       <= {hit_s_q[1:0], bus.hit};
      miss_s_q      <= {miss_s_q[0], bus.miss};
      state_q       <= state_d;
      frog_cnt_q    <= frog_cnt_d;
      ball_cnt_q    <= ball_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      ball_period_q <= ball_period_d;
      score_cur_q   <= score_cur_d;
      score_best_q  <= score_best_d;
    end
  end

  assign bus.frog_tick   = frog_tick;
  assign bus.ball_tick   = ball_tick;
  assign bus.running     = (state_q == StRun);
  assign bus.game_reset  = (state_q != StRun);
  assign bus.state       = state_q;
  assign bus.ball_period = ball_period_q;
  assign bus.score_cur   = score_cur_q;
  assign bus.score_best  = score_best_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: stimulus queues expectations, a negedge monitor checks them.
module tb_game_sequencer;
  localparam int unsigned PW = 8;

  logic       clk;
  logic       rst;
  logic [3:0] btn;  // {d, u, l, r}, active-low

  initial clk = 1'b0;
  always #5 clk = ~clk;

  game_sequencer_if #(.PERIOD_W(PW)) bus ();

  assign bus.move_r = btn[0];
  assign bus.move_l = btn[1];
  assign bus.move_u = btn[2];
  assign bus.move_d = btn[3];

  game_sequencer #(
    .PERIOD_W        (PW),
    .FROG_PERIOD     (4),
    .BALL_PERIOD_INIT(10),
    .BALL_PERIOD_STEP(4),
    .BALL_PERIOD_MIN (4),
    .OVER_HOLD       (5)
  ) dut (
    .CLOCK_50(clk),
    .reset   (rst),
    .bus     (bus)
  );

  typedef enum int {FState, FRunning, FGameReset, FFrogTick, FBallTick, FPeriod, FScore, FBest}
    field_e;
  typedef struct {
    string  name;
    field_e fld;
    int     exp;
  } chk_t;

  chk_t chk_q[$];
  int   frog_q[$];
  int   ball_q[$];
  int   n_chk   = 0;
  int   n_fail  = 0;
  int   run_cyc = 0;
  bit   tick_mon = 1'b0;

  chk_t mon_c;
  int   mon_act;
  bit   exp_f, exp_b;

  function automatic int read_field(field_e f);
    case (f)
      FState:     return int'(bus.state);
      FRunning:   return int'(bus.running);
      FGameReset: return int'(bus.game_reset);
      FFrogTick:  return int'(bus.frog_tick);
      FBallTick:  return int'(bus.ball_tick);
      FPeriod:    return int'(bus.ball_period);
      FScore:     return int'(bus.score_cur);
      default:    return int'(bus.score_best);
    endcase
  endfunction

  task automatic expect_f(input string name, input field_e f, input int exp);
    chk_q.push_back('{name, f, exp});
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hit_pulse();
    bus.hit = 1'b1;
    step(1);
    bus.hit = 1'b0;
    step(1);
  endtask

  task automatic press(input int idx);
    btn[idx] = 1'b0;
    step(1);
    btn = 4'hF;
  endtask

  // Monitor: drains pending expectations and checks tick timing against RUN cycle numbers.
  initial begin
    forever begin
      @(negedge clk);
      while (chk_q.size() > 0) begin
        mon_c   = chk_q.pop_front();
        mon_act = read_field(mon_c.fld);
        check_int(mon_c.name, mon_act, mon_c.exp);
      end
      if (!bus.running) run_cyc = 0;
      else run_cyc++;
      if (tick_mon) begin
        exp_f = (frog_q.size() > 0) && (frog_q[0] == run_cyc);
        exp_b = (ball_q.size() > 0) && (ball_q[0] == run_cyc);
        check_int($sformatf("frog_tick@run%0d", run_cyc), int'(bus.frog_tick), int'(exp_f));
        check_int($sformatf("ball_tick@run%0d", run_cyc), int'(bus.ball_tick), int'(exp_b));
        if (exp_f) void'(frog_q.pop_front());
        if (exp_b) void'(ball_q.pop_front());
      end
    end
  end

  initial begin
    rst      = 1'b1;
    btn      = 4'hF;
    bus.hit  = 1'b0;
    bus.miss = 1'b0;
    step(2);
    expect_f("rst_state", FState, 0);
    expect_f("rst_running", FRunning, 0);
    expect_f("rst_game_reset", FGameReset, 1);
    expect_f("rst_frog_tick", FFrogTick, 0);
    expect_f("rst_ball_tick", FBallTick, 0);
    expect_f("rst_period", FPeriod, 10);
    expect_f("rst_score", FScore, 0);
    expect_f("rst_best", FBest, 0);
    step(1);
    rst = 1'b0;
    step(1);

    // Game 1: start latency and tick cadence
    press(2);
    step(1);
    expect_f("start_edge2_state", FState, 0);
    frog_q   = '{4, 8, 12, 16, 20};
    ball_q   = '{10, 20};
    tick_mon = 1'b1;
    step(1);
    expect_f("start_edge3_state", FState, 1);
    expect_f("start_running", FRunning, 1);
    expect_f("start_game_reset", FGameReset, 0);
    expect_f("start_period", FPeriod, 10);
    expect_f("start_score", FScore, 0);
    step(21);
    tick_mon = 1'b0;
    check_int("frog_ticks_missing", frog_q.size(), 0);
    check_int("ball_ticks_missing", ball_q.size(), 0);

    // Spaced hits: period 10 -> 6 -> 4 -> 4
    hit_pulse(); step(3);
    expect_f("hit1_period", FPeriod, 6);
    expect_f("hit1_score", FScore, 'h001);
    hit_pulse(); step(3);
    expect_f("hit2_period", FPeriod, 4);
    expect_f("hit2_score", FScore, 'h002);
    hit_pulse(); step(3);
    expect_f("hit3_period", FPeriod, 4);
    expect_f("hit3_score", FScore, 'h003);

    // Miss with a simultaneous hit: miss wins
    bus.hit  = 1'b1;
    bus.miss = 1'b1;
    step(1);
    bus.hit = 1'b0;
    step(1);
    expect_f("miss_pre_state", FState, 1);
    step(1);
    expect_f("miss_state", FState, 2);
    expect_f("miss_score", FScore, 'h003);
    expect_f("miss_best", FBest, 'h003);
    expect_f("over_running", FRunning, 0);
    expect_f("over_game_reset", FGameReset, 1);
    bus.miss = 1'b0;
    press(1);
    step(3);
    expect_f("over_hold_state", FState, 2);
    expect_f("over_frog_tick", FFrogTick, 0);
    expect_f("over_ball_tick", FBallTick, 0);
    step(1);
    expect_f("over_to_idle", FState, 0);
    expect_f("idle_score_kept", FScore, 'h003);
    step(3);
    expect_f("over_press_ignored", FState, 0);

    // Game 2: held hit counts once, lower score leaves best alone
    press(0);
    step(2);
    expect_f("g2_state", FState, 1);
    expect_f("g2_score_clr", FScore, 0);
    expect_f("g2_period_init", FPeriod, 10);
    bus.hit = 1'b1;
    step(20);
    bus.hit = 1'b0;
    step(4);
    expect_f("held_hit_score", FScore, 'h001);
    expect_f("held_hit_period", FPeriod, 6);
    bus.miss = 1'b1;
    step(3);
    expect_f("g2_over", FState, 2);
    expect_f("g2_best_kept", FBest, 'h003);
    bus.miss = 1'b0;
    step(5);
    expect_f("g2_idle", FState, 0);

    // Game 3: BCD carry and saturation
    press(3);
    step(2);
    expect_f("g3_state", FState, 1);
    repeat (99) hit_pulse();
    step(3);
    expect_f("score_099", FScore, 'h099);
    expect_f("period_floor", FPeriod, 4);
    hit_pulse(); step(3);
    expect_f("score_carry_100", FScore, 'h100);
    repeat (899) hit_pulse();
    step(3);
    expect_f("score_999", FScore, 'h999);
    hit_pulse(); step(3);
    expect_f("score_sat_999", FScore, 'h999);
    expect_f("g3_still_run", FState, 1);
    expect_f("g3_best_before_rst", FBest, 'h003);
    step(1);

    // Asynchronous reset mid-RUN: checked before any further clock edge
    rst = 1'b1;
    expect_f("arst_state", FState, 0);
    expect_f("arst_running", FRunning, 0);
    expect_f("arst_best", FBest, 0);
    expect_f("arst_score", FScore, 0);
    expect_f("arst_period", FPeriod, 10);
    expect_f("arst_frog_tick", FFrogTick, 0);
    expect_f("arst_ball_tick", FBallTick, 0);
    step(1);
    rst = 1'b0;
    step(2);
    expect_f("post_rst_idle", FState, 0);
    step(1);
    check_int("scoreboard_drained", chk_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Top-level game controller for the frogger/ball playfield.
- Sequences the game through idle, running and game-over phases.
- Generates the frog-move and ball-move tick enables from CLOCK_50, and shortens the ball period on every hit.
- Keeps the current and best score in BCD for the 7-segment decoders; the VGA/object datapath consumes its ticks and reports hit/miss back.

Parameters:
- PERIOD_W, 22, width of all period counters and the ball_period register.
- FROG_PERIOD, 2000000, CLOCK_50 cycles per frog_tick (25 Hz).
- BALL_PERIOD_INIT, 2000000, ball period loaded at game start.
- BALL_PERIOD_STEP, 100000, period decrement per hit.
- BALL_PERIOD_MIN, 800000, floor of the ball period.
- OVER_HOLD, 50000000, cycles spent in OVER before returning to IDLE.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high; all state cleared.
- move_r  in  1  button, active-low, asynchronous to clock.
- move_l  in  1  button, active-low.
- move_u  in  1  button, active-low.
- move_d  in  1  button, active-low.
- hit  in  1  ball/frog collision from datapath; level, any width.
- miss  in  1  ball left the bottom of the field; level.
- frog_tick  out  1  one-cycle enable for frog movement.
- ball_tick  out  1  one-cycle enable for ball movement.
- running  out  1  high in RUN.
- game_reset  out  1  high in IDLE and OVER; datapath holds objects at start positions.
- state  out  2  00=IDLE, 01=RUN, 10=OVER.
- ball_period  out  PERIOD_W  current ball period.
- score_cur  out  12  3-digit BCD current score; [11:8] hundreds.
- score_best  out  12  3-digit BCD best score.

Behaviour:
- Reset values (async):
  - state=IDLE, running=0, game_reset=1, frog_tick=0, ball_tick=0.
  - score_cur=0, score_best=0, ball_period=BALL_PERIOD_INIT.
  - All counters and synchronizers 0; button synchronizers reset to released (1).
- Input conditioning:
  - Each button passes through a 2-flop synchronizer; any_press = any synchronized button low.
  - hit passes through a 2-flop synchronizer plus edge detect: hit_ev is a 1-cycle pulse on the rising edge. A held hit counts once.
  - miss passes through a 2-flop synchronizer, level-sensitive.
- IDLE:
  - Ticks held 0; frog_cnt, ball_cnt and hold_cnt held 0.
  - On any_press: next state RUN; the same edge loads score_cur=0 and ball_period=BALL_PERIOD_INIT.
  - Press-to-running latency: 3 clock edges after the raw button falls.
- RUN:
  - frog_cnt counts 0..FROG_PERIOD-1 and wraps. frog_tick=1 in the cycle frog_cnt==FROG_PERIOD-1; the first tick is the FROG_PERIOD-th RUN cycle.
  - ball_cnt counts up. ball_tick=1 in any cycle with ball_cnt >= ball_period-1, and ball_cnt returns to 0 on that cycle.
  - If ball_period shrinks below the current count, ball_tick fires in the next cycle. No tick is lost and none is duplicated.
  - ticks are combinationally decoded from registered counters; no glitch requirement beyond single-cycle width.
  - On hit_ev:
    - score_cur increments in BCD with per-digit carry, saturating at 999.
    - If ball_period > BALL_PERIOD_MIN: ball_period = (ball_period - BALL_PERIOD_MIN > BALL_PERIOD_STEP) ? ball_period - BALL_PERIOD_STEP : BALL_PERIOD_MIN.
    - Otherwise ball_period is unchanged.
  - On synchronized miss: next state OVER.
    - The same edge sets score_best = score_cur if score_cur > score_best (BCD compare equals binary compare of the 12-bit value).
  - hit_ev and miss in the same cycle: miss wins, the hit is discarded, score_cur is not incremented.
  - Buttons are ignored in RUN.
- OVER:
  - Ticks 0; hold_cnt counts 0..OVER_HOLD-1, then state returns to IDLE (hold_cnt cleared).
  - Buttons, hit and miss are ignored.
  - score_cur remains displayed until the next game start.
- Reset asserted mid-game: immediate return to reset values. score_best is lost; there is no persistence.
- All arithmetic is unsigned. Counters are PERIOD_W bits, and parameters must be < 2^PERIOD_W.

Test Plan:
Bench parameters: FROG_PERIOD=4, BALL_PERIOD_INIT=10, BALL_PERIOD_STEP=4, BALL_PERIOD_MIN=4, OVER_HOLD=5, PERIOD_W=8.
- Reset, then drive move_u low for 1 cycle -> running=1 and state=01 on the 3rd edge. frog_tick pulses at RUN cycles 4, 8, 12; ball_tick at cycles 10, 20. game_reset=0.
- In RUN, pulse hit three times, spaced -> ball_period 10->6->4->4; score_cur 0x001, 0x002, 0x003.
- Hold hit high for 20 cycles -> score_cur increments exactly once.
- Preload via 999 hits (score_cur=0x999), then one more hit -> stays 0x999. Also check 0x099 -> 0x100 carry.
- Score 0x003, then assert miss together with a hit pulse -> state=10, score_cur stays 0x003, score_best=0x003. IDLE after 5 cycles; presses during OVER are ignored.
- Second game scoring 0x001, then miss -> score_best remains 0x003. Assert reset mid-RUN -> state=00, score_best=0, ball_period=10, ticks 0 immediately (asynchronous).
